// File: rtl/fanout_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fanout_pkg : shared defaults and state encoding for the fanout fork control
// Revision   : 1.0
// ---------------------------------------------------------------------------
package fanout_pkg;

  localparam int NUM_DST_DEF = 6;
  localparam int DATA_W_DEF  = 16;
  localparam int STALL_W     = 16;

  localparam logic [STALL_W-1:0] C_STALL_MAX = '1;
  localparam logic [STALL_W-1:0] C_STALL_ONE = STALL_W'(1);

  localparam logic [0:0] C_ST_IDLE    = 1'b0;
  localparam logic [0:0] C_ST_PARTIAL = 1'b1;

  typedef enum logic [0:0] {
    IDLE    = C_ST_IDLE,
    PARTIAL = C_ST_PARTIAL
  } fork_state_e;

endpackage
`default_nettype wire

// File: rtl/fanout_ready_merge.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fanout_ready_merge : upstream ready is high once every enabled destination
//                      has taken the token or is ready to take it now
// Revision           : 1.0
// ---------------------------------------------------------------------------
module fanout_ready_merge
  import fanout_pkg::*;
#(
  parameter int NUM_DST = NUM_DST_DEF
) (
  input  logic [NUM_DST-1:0] mask,
  input  logic [NUM_DST-1:0] done,
  input  logic [NUM_DST-1:0] out_ready,
  output logic               in_ready
);

  assign in_ready = &(~mask | done | out_ready);

endmodule
`default_nettype wire

// File: rtl/fanout_fork_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fanout_fork_ctrl : broadcasts one upstream token to a masked set of
//                    destinations, remembering which have already taken it
// Revision         : 1.0
// ---------------------------------------------------------------------------
module fanout_fork_ctrl
  import fanout_pkg::*;
#(
  parameter int NUM_DST = NUM_DST_DEF,
  parameter int DATA_W  = DATA_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                cfg_wr,
  input  logic [NUM_DST-1:0]  cfg_mask,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic [NUM_DST-1:0]  out_valid,
  output logic [DATA_W-1:0]   out_data,
  input  logic [NUM_DST-1:0]  out_ready,
  output logic                cfg_busy,
  output logic [STALL_W-1:0]  stall_cnt
);

  logic [NUM_DST-1:0] mask_q;
  logic [NUM_DST-1:0] done_q;
  logic [STALL_W-1:0] stall_q;

  logic [NUM_DST-1:0] w_accept;
  logic               w_cfg_take;
  logic               w_stall;
  fork_state_e        w_state;

  fanout_ready_merge #(
    .NUM_DST   (NUM_DST)
  ) u_ready_merge (
    .mask      (mask_q),
    .done      (done_q),
    .out_ready (out_ready),
    .in_ready  (in_ready)
  );

  // The state is fully implied by the delivered set: any bit set means PARTIAL.
  assign w_state    = (|done_q) ? PARTIAL : IDLE;
  assign cfg_busy   = (w_state == PARTIAL);
  assign out_valid  = {NUM_DST{in_valid}} & mask_q & ~done_q;
  assign out_data   = in_data;
  assign w_accept   = out_valid & out_ready;
  assign w_cfg_take = cfg_wr & ~cfg_busy;
  assign w_stall    = in_valid & ~in_ready;
  assign stall_cnt  = stall_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      done_q <= '0;
    end else if (in_valid) begin
      if (in_ready) begin
        done_q <= '0;
      end else begin
        done_q <= done_q | w_accept;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask_q <= '0;
    end else if (w_cfg_take) begin
      mask_q <= cfg_mask;
    end
  end

  // A taken configuration write restarts the stall count, overriding an increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_q <= '0;
    end else if (w_cfg_take) begin
      stall_q <= '0;
    end else if (w_stall && (stall_q != C_STALL_MAX)) begin
      stall_q <= stall_q + C_STALL_ONE;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fanout_fork_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_fanout_fork_ctrl : scoreboard bench with a token-level reference model
// Revision            : 1.0
// ---------------------------------------------------------------------------
module tb_fanout_fork_ctrl;

  localparam int N = 6;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cfg_wr;
  logic [N-1:0] cfg_mask;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic [N-1:0] out_valid;
  logic [W-1:0] out_data;
  logic [N-1:0] out_ready;
  logic         cfg_busy;
  logic [15:0]  stall_cnt;

  always #5 clk = ~clk;

  fanout_fork_ctrl #(
    .NUM_DST   (N),
    .DATA_W    (W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_wr    (cfg_wr),
    .cfg_mask  (cfg_mask),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .cfg_busy  (cfg_busy),
    .stall_cnt (stall_cnt)
  );

  typedef struct {
    logic         rdy;
    logic [N-1:0] ov;
    logic [N-1:0] acc;
    logic         busy;
    logic [15:0]  stall;
    logic [W-1:0] od;
  } cyc_t;

  typedef struct {
    int           dst;
    logic [W-1:0] data;
  } tok_t;

  cyc_t cq[$];
  tok_t dq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model: which destinations are enabled, which already hold the
  // current token, and how many cycles upstream has been made to wait.
  bit m_mask[N];
  bit m_served[N];
  int m_stall;
  bit last_stalled;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_mask[i]   = 1'b0;
      m_served[i] = 1'b0;
    end
    m_stall = 0;
  endtask

  task automatic step(input bit rst, input bit v, input logic [W-1:0] d,
                      input logic [N-1:0] ord, input bit cw, input logic [N-1:0] cm);
    cyc_t e;
    bit   all_ok;
    bit   busy;
    @(posedge clk);
    #1;
    rst_n = ~rst; in_valid = v; in_data = d; out_ready = ord; cfg_wr = cw; cfg_mask = cm;
    all_ok = 1'b1;
    busy   = 1'b0;
    e.ov   = '0;
    e.acc  = '0;
    for (int i = 0; i < N; i++) begin
      if (m_served[i]) busy = 1'b1;
      if (m_mask[i] && !m_served[i] && !ord[i]) all_ok = 1'b0;
      e.ov[i]  = v && m_mask[i] && !m_served[i];
      e.acc[i] = e.ov[i] && ord[i];
      if (e.acc[i]) dq.push_back('{i, d});
    end
    e.rdy   = all_ok;
    e.busy  = busy;
    e.stall = 16'(m_stall);
    e.od    = d;
    cq.push_back(e);
    last_stalled = v && !all_ok && !rst;
    if (rst) begin
      model_clear();
    end else begin
      if (v) begin
        for (int i = 0; i < N; i++) begin
          if (all_ok) m_served[i] = 1'b0;
          else if (e.acc[i]) m_served[i] = 1'b1;
        end
      end
      if (cw && !busy) begin
        for (int i = 0; i < N; i++) m_mask[i] = cm[i];
        m_stall = 0;
      end else if (v && !all_ok && m_stall < 65535) begin
        m_stall++;
      end
    end
  endtask

  // Monitor: one expectation per driven cycle, plus one token per handshake.
  initial begin
    cyc_t e;
    tok_t t;
    forever begin
      @(negedge clk);
      if (cq.size() != 0) begin
        e = cq.pop_front();
        chk("in_ready",  32'(in_ready),  32'(e.rdy));
        chk("out_valid", 32'(out_valid), 32'(e.ov));
        chk("accept",    32'(out_valid & out_ready), 32'(e.acc));
        chk("cfg_busy",  32'(cfg_busy),  32'(e.busy));
        chk("stall_cnt", 32'(stall_cnt), 32'(e.stall));
        chk("out_data",  32'(out_data),  32'(e.od));
        for (int i = 0; i < N; i++) begin
          if (out_valid[i] && out_ready[i]) begin
            if (dq.size() == 0) begin
              total++;
              bad++;
              $display("FAIL tok_unexpected dst=%0d actual=handshake required=none", i);
            end else begin
              t = dq.pop_front();
              chk("tok_dst",  32'(i),        32'(t.dst));
              chk("tok_data", 32'(out_data), 32'(t.data));
            end
          end
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [W-1:0] d;
    bit           v;
    rst_n = 1'b0; cfg_wr = 1'b0; cfg_mask = '0; in_valid = 1'b0; in_data = '0; out_ready = '0;
    model_clear();
    last_stalled = 1'b0;
    repeat (2) @(posedge clk);

    // All enabled, all ready: four back-to-back tokens, no stalls.
    step(0, 0, '0, '0, 1, 6'b111111);
    for (int k = 0; k < 4; k++) step(0, 1, W'(16'h1000 + k), 6'b111111, 0, '0);

    // Staggered readiness across two destinations.
    step(0, 0, '0, '0, 1, 6'b000101);
    step(0, 1, 16'hA5A5, 6'b000001, 0, '0);
    step(0, 1, 16'hA5A5, 6'b000100, 0, '0);
    step(0, 0, '0, '0, 0, '0);

    // Configuration write while partial is dropped; repeated in idle it lands.
    step(0, 1, 16'hBEEF, 6'b000001, 0, '0);
    step(0, 1, 16'hBEEF, 6'b000000, 1, 6'b000011);
    step(0, 1, 16'hBEEF, 6'b000100, 0, '0);
    step(0, 0, '0, '0, 1, 6'b000011);
    step(0, 1, 16'h0C0C, 6'b000011, 0, '0);
    step(0, 1, 16'h0D0D, 6'b000001, 0, '0);
    step(0, 1, 16'h0D0D, 6'b000010, 0, '0);

    // Empty mask sinks tokens.
    step(0, 0, '0, '0, 1, 6'b000000);
    for (int k = 0; k < 3; k++) step(0, 1, W'($urandom), N'($urandom), 0, '0);

    // Reset while partial abandons the token.
    step(0, 0, '0, '0, 1, 6'b000111);
    step(0, 1, 16'h7777, 6'b000001, 0, '0);
    step(1, 1, 16'h7777, 6'b000000, 0, '0);
    step(0, 1, 16'h7777, 6'b000000, 0, '0);
    step(0, 0, '0, '0, 0, '0);

    // Randomized traffic with payload held while stalled.
    d = '0;
    for (int k = 0; k < 3000; k++) begin
      if (!last_stalled) begin
        v = ($urandom_range(0, 3) != 0);
        d = W'($urandom);
      end else begin
        v = 1'b1;
      end
      step(($urandom_range(0, 199) == 0), v, d, N'($urandom),
           ($urandom_range(0, 9) == 0), N'($urandom));
    end

    // Long stall saturates the counter.
    step(1, 0, '0, '0, 0, '0);
    step(0, 0, '0, '0, 1, 6'b111111);
    for (int k = 0; k < 70000; k++) step(0, 1, 16'h5A5A, 6'b000000, 0, '0);
    step(0, 1, 16'h5A5A, 6'b111111, 0, '0);
    step(0, 0, '0, '0, 0, '0);

    @(posedge clk);
    @(negedge clk);
    #1;
    chk("cq_drain", 32'(cq.size()), 32'd0);
    chk("dq_drain", 32'(dq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
